mem_copy_dma: RTL and testbench

//  Bus-master copy engine driving the dual-port data memory. Reads through the read-only

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_range_check.sv | 30 +++
 rtl/mem_copy_dma.sv | 118 +++++++++++
 tb/tb_mem_copy_dma.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the mem_copy_dma copy engine and its range checker.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;

  localparam logic [31:0] STEP_WORD = 32'd4;
  localparam logic [31:0] STEP_BYTE = 32'd1;

  function automatic logic [31:0] elem_step(input logic byte_mode);
    return byte_mode ? STEP_BYTE : STEP_WORD;
  endfunction

endpackage

// File: rtl/dma_range_check.sv
// Command validation for mem_copy_dma: word alignment and end-of-memory bounds.
// Sums are 33 bits wide so a pointer that wraps past 2^32 is rejected, not accepted.
module dma_range_check
  import dma_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 16
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             byte_mode,
  output logic             ok
);

  logic [32:0] span;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic        misalign;

  always_comb begin
    span     = byte_mode ? 33'(len) : (33'(len) << 2);
    src_end  = {1'b0, src} + span;
    dst_end  = {1'b0, dst} + span;
    misalign = (elem_step(byte_mode) == STEP_WORD) &&
               ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00));
    ok       = !misalign && (src_end <= 33'(MEM_BYTES)) && (dst_end <= 33'(MEM_BYTES));
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Two-stage bus-master copy engine: stage 1 reads via Address1, stage 2 writes via Address.
// Optional DMA_CHECKSUM_EN adds a running sum of written elements on port checksum.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             byte_mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] xfer_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_we,
  output logic [31:0]      mem_addr1,
  input  logic [31:0]      mem_rdata1
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  dma_state_t       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [LEN_W-1:0] rem;
  logic             bm_q;
  logic [31:0]      data_q;
  logic [31:0]      wa_q;
  logic             wv_q;
  logic             err_q;
  logic             cmd_ok;
  logic             take;
  logic             wr_en;
  logic [31:0]      step;

  dma_range_check #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) u_range_check (
    .src       (src_addr),
    .dst       (dst_addr),
    .len       (xfer_len),
    .byte_mode (byte_mode),
    .ok        (cmd_ok)
  );

  assign take  = (state == IDLE) && start && !abort;
  assign step  = elem_step(bm_q);
  // abort kills the stage-2 write combinationally, before the memory can clock it
  assign wr_en = wv_q && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      rem     <= '0;
      bm_q    <= 1'b0;
      data_q  <= '0;
      wa_q    <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wv_q <= 1'b0;
      case (state)
        IDLE: if (take) begin
          err_q <= !cmd_ok;
          if (cmd_ok) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            rem     <= xfer_len;
            bm_q    <= byte_mode;
            // zero-length still spends a cycle in DRAIN so done lands at start+len+2
            state   <= (xfer_len == '0) ? DRAIN : RUN;
          end
        end
        RUN: if (abort) begin
          state <= DONE;
        end else begin
          data_q  <= bm_q ? {24'b0, mem_rdata1[7:0]} : mem_rdata1;
          wa_q    <= dst_ptr;
          wv_q    <= 1'b1;
          src_ptr <= src_ptr + step;
          dst_ptr <= dst_ptr + step;
          rem     <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state <= DRAIN;
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    err       = err_q;
    mem_we    = wr_en ? (bm_q ? MW_BYTE : MW_WORD) : MW_NONE;
    mem_addr  = wv_q ? wa_q : '0;
    mem_wdata = wv_q ? data_q : '0;
    mem_addr1 = (state == RUN) ? src_ptr : '0;
  end

`ifdef DMA_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        checksum <= '0;
    else if (take)  checksum <= '0;
    else if (wr_en) checksum <= checksum + mem_wdata;
  end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: byte-array memory, directed scenarios, random copies.
module tb_mem_copy_dma;
  localparam int MEM_BYTES = 1024;
  localparam int LEN_W     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             byte_mode = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic             busy, done, err;
  logic [31:0]      mem_addr, mem_wdata, mem_addr1, mem_rdata1;
  logic [1:0]       mem_we;
`ifdef DMA_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int nw, first_w, last_w, done_cyc, done_cnt;
  int t0;
  logic [31:0] ref_sum;
  logic [7:0]  mem     [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [1:0]  wp_we = 2'b00;
  logic [31:0] wp_a, wp_d;

  mem_copy_dma #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .byte_mode(byte_mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_addr1(mem_addr1), .mem_rdata1(mem_rdata1)
`ifdef DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Combinational read port, little-endian, byte at the address lands in [7:0]
  always_comb begin
    mem_rdata1 = '0;
    for (int b = 0; b < 4; b++)
      if (mem_addr1 + 32'(b) < 32'(MEM_BYTES)) mem_rdata1[8*b +: 8] = mem[mem_addr1 + 32'(b)];
  end

  always @(negedge clk) begin
    wp_we = mem_we; wp_a = mem_addr; wp_d = mem_wdata;
    if (mem_we != 2'b00) begin
      nw++;
      if (first_w < 0) first_w = cyc;
      last_w = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  always @(posedge clk) begin
    cyc++;
    if (wp_we == 2'b10) begin
      for (int b = 0; b < 4; b++)
        if (wp_a + 32'(b) < 32'(MEM_BYTES)) mem[wp_a + 32'(b)] = wp_d[8*b +: 8];
    end else if (wp_we == 2'b11 && wp_a < 32'(MEM_BYTES)) begin
      mem[wp_a] = wp_d[7:0];
    end
    wp_we = 2'b00;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_ok(input logic [31:0] s, input logic [31:0] d, input int n, input bit bm);
    longint span = bm ? longint'(n) : 4 * longint'(n);
    if (!bm && (s % 4 != 0 || d % 4 != 0)) return 1'b0;
    return (longint'(s) + span <= MEM_BYTES) && (longint'(d) + span <= MEM_BYTES);
  endfunction

  function automatic bit ovl(input longint a, input longint b, input longint span);
    return span > 0 && a < b + span && b < a + span;
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] peek_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic poke(input int a, input logic [7:0] v);
    mem[a] = v; ref_mem[a] = v;
  endtask

  task automatic poke_word(input int a, input logic [31:0] v);
    for (int b = 0; b < 4; b++) poke(a + b, v[8*b +: 8]);
  endtask

  // Plain memcpy of n elements; ref_sum is the sum of the copied elements
  task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit bm);
    int step;
    logic [31:0] w;
    step = bm ? 1 : 4;
    ref_sum = '0;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < step; b++) w[8*b +: 8] = ref_mem[int'(s) + i*step + b];
      ref_sum += w;
      for (int b = 0; b < step; b++) ref_mem[int'(d) + i*step + b] = w[8*b +: 8];
    end
  endtask

  task automatic clr_mon();
    nw = 0; first_w = -1; last_w = -1; done_cyc = -1; done_cnt = 0;
  endtask

  // Start is high for exactly one cycle; t0 is that cycle's number
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n, input bit bm,
                       input bit ab, output int tstart);
    @(posedge clk); #1;
    start = 1'b1; abort = ab; src_addr = s; dst_addr = d; xfer_len = LEN_W'(n); byte_mode = bm;
    tstart = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin @(posedge clk); #1; k++; end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n, input bit bm);
    int ts;
    bit ok;
    ok = ref_ok(s, d, n, bm);
    clr_mon();
    issue(s, d, n, bm, 1'b0, ts);
    if (ok) begin
      ref_copy(s, d, n, bm);
      wait_done(n + 8);
      chk("done_at", done_cyc, ts + n + 2);
      chk("done_cnt", done_cnt, 1);
      chk("n_writes", nw, n);
      if (n > 0) begin
        chk("first_wr", first_w, ts + 2);
        chk("last_wr", last_w, ts + n + 1);
      end
      chk("err_ok", err, 0);
      chk("mem", mem_diff(), 0);
`ifdef DMA_CHECKSUM_EN
      chk("checksum", checksum, ref_sum);
`endif
    end else begin
      repeat (4) begin @(posedge clk); #1; end
      chk("err_rej", err, 1);
      chk("busy_rej", busy, 0);
      chk("wr_rej", nw, 0);
      chk("done_rej", done_cnt, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) poke(i, 8'($urandom));
    clr_mon();
    #2;
    chk("rst_ctl", {busy, done, err, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_addr1", mem_addr1, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1; rst = 1'b0;

    // word copy with fixed data
    poke_word(32'h0, 32'h11); poke_word(32'h4, 32'h22);
    poke_word(32'h8, 32'h33); poke_word(32'hC, 32'h44);
    run_cmd(32'h0, 32'h40, 4, 1'b0);
    chk("s1_w40", peek_word(32'h40), 32'h11);
    chk("s1_w4c", peek_word(32'h4C), 32'h44);
`ifdef DMA_CHECKSUM_EN
    chk("s1_csum", checksum, 32'hAA);
`endif

    // single byte copy, neighbours untouched
    poke(5, 8'h58); poke(32'h20, 8'hA1); poke(32'h22, 8'hA2);
    run_cmd(32'h5, 32'h21, 1, 1'b1);
    chk("s2_b21", mem[32'h21], 8'h58);
    chk("s2_b20", mem[32'h20], 8'hA1);
    chk("s2_b22", mem[32'h22], 8'hA2);

    // rejected commands, then start+abort in the same cycle
    run_cmd(32'h2, 32'h80, 1, 1'b0);
    run_cmd(32'h0, 32'(MEM_BYTES - 4), 2, 1'b0);
    clr_mon();
    issue(32'h0, 32'h80, 1, 1'b0, 1'b1, t0);
    repeat (4) begin @(posedge clk); #1; end
    chk("ab_err_held", err, 1);
    chk("ab_busy", busy, 0);
    chk("ab_nw", nw + done_cnt, 0);

    // zero length
    run_cmd(32'h10, 32'h90, 0, 1'b0);

    // abort after two writes, with an ignored start while busy
    clr_mon();
    issue(32'h100, 32'h200, 8, 1'b0, 1'b0, t0);
    @(posedge clk); #1;
    start = 1'b1; src_addr = 32'h0; dst_addr = 32'h300; xfer_len = LEN_W'(3);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; abort = 1'b1; #1;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 1);
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_busy_off", busy, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_nw", nw, 2);
    chk("abort_done_at", done_cyc, t0 + 5);
    chk("abort_done_cnt", done_cnt, 1);
    ref_copy(32'h100, 32'h200, 2, 1'b0);
    chk("abort_mem", mem_diff(), 0);
`ifdef DMA_CHECKSUM_EN
    chk("abort_csum", checksum, ref_sum);
`endif

    // asynchronous reset mid-RUN; the pending write is lost
    clr_mon();
    issue(32'h140, 32'h280, 6, 1'b0, 1'b0, t0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("mrst_ctl", {busy, done, err, mem_we}, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_addr1", mem_addr1, 0);
    chk("mrst_wdata", mem_wdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mrst_nw", nw, 1);
    chk("mrst_done", done_cnt, 0);
    ref_copy(32'h140, 32'h280, 1, 1'b0);
    chk("mrst_mem", mem_diff(), 0);
`ifdef DMA_CHECKSUM_EN
    chk("mrst_csum", checksum, 0);
`endif
    run_cmd(32'h140, 32'h280, 6, 1'b0);

    // random non-overlapping copies plus assorted invalid commands
    for (int it = 0; it < 30; it++) begin
      logic [31:0] s, d;
      int n, step, span, kind;
      bit bm;
      bm   = 1'($urandom_range(0, 1));
      n    = int'($urandom_range(0, 12));
      step = bm ? 1 : 4;
      span = n * step;
      kind = int'($urandom_range(0, 7));
      s = $urandom_range(0, MEM_BYTES - span);
      d = $urandom_range(0, MEM_BYTES - span);
      if (!bm) begin s[1:0] = 2'b00; d[1:0] = 2'b00; end
      for (int r = 0; r < 16 && ovl(s, d, span); r++) begin
        d = $urandom_range(0, MEM_BYTES - span);
        if (!bm) d[1:0] = 2'b00;
      end
      if (ovl(s, d, span)) n = 0;
      case (kind)
        0: s[0] = 1'b1;
        1: d = 32'(MEM_BYTES - span + step);
        2: s = 32'hFFFF_FFFC;
        default: ;
      endcase
      run_cmd(s, d, n, bm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
